dadda_mul_pipe: RTL and testbench

//  Parametrised NxN Dadda-tree multiplier, pipelined over 3 registered stages with

---
 rtl/dadda_mul_pipe.sv | 172 +++++++++++++++++
 tb/tb_dadda_mul_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mul_pipe.sv
// Pipelined NxN Dadda multiplier (S1 partial products, S2 tree, S3 final add) with valid/ready.
// Define DADDA_SIGNED_EN for two's-complement operands via Baugh-Wooley partial products.
module dadda_mul_pipe #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] Mul,
    output logic [1:0]     in_flight
);
    localparam int W    = 2 * N;
    localparam int MAXH = N + 1;
    localparam int NDS  = 10;   // d = 2,3,4,6,9,13,19,28,42,63 covers N up to 32

    function automatic int dseq(input int k);
        int d;
        d = 2;
        for (int i = 0; i < k; i++) d = (d * 3) / 2;
        return d;
    endfunction

    logic                  en;
    logic [3:1]            vld_pipe_q, vld_pipe_d;
    logic [1:0]            inflight_q, inflight_d;
    logic [N-1:0][N-1:0]   pp_q, pp_d;
    logic [W-1:0]          row0_q, row0_d, row1_q, row1_d;
    logic [W-1:0]          mul_q, mul_d;

    assign en        = ~vld_pipe_q[3] | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe_q[3];
    assign Mul       = mul_q;
    assign in_flight = inflight_q;

    assign vld_pipe_d = {vld_pipe_q[2:1], in_valid};
    assign inflight_d = {1'b0, vld_pipe_d[1]} + {1'b0, vld_pipe_d[2]} + {1'b0, vld_pipe_d[3]};

    // S1: pp[i][j] = A[i] & B[j], weight 2^(i+j)
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pp_d[i][j] = A[i] & B[j];
`ifdef DADDA_SIGNED_EN
                if ((i == N-1) != (j == N-1)) pp_d[i][j] = ~pp_d[i][j];
`endif
            end
        end
    end

    // S2: column heights are static, so every loop below unrolls into a fixed HA/FA network.
    // Bits are packed from LSB upward in each column word; hgt tracks how many are live.
    always_comb begin : dadda_tree
        logic [MAXH-1:0] col  [W];
        logic [MAXH-1:0] ncol [W];
        int              hgt  [W];
        int              nh   [W];
        logic [MAXH-1:0] sh;
        int              d;
        int              idx;
        logic            x, y, z;

        sh  = '0;
        d   = 0;
        idx = 0;
        x   = 1'b0;
        y   = 1'b0;
        z   = 1'b0;
        for (int c = 0; c < W; c++) begin
            col[c]  = '0;
            ncol[c] = '0;
            hgt[c]  = 0;
            nh[c]   = 0;
        end

        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                col[i+j] = col[i+j] | ({{(MAXH-1){1'b0}}, pp_q[i][j]} << hgt[i+j]);
                hgt[i+j] = hgt[i+j] + 1;
            end
        end
`ifdef DADDA_SIGNED_EN
        col[N]   = col[N]   | ({{(MAXH-1){1'b0}}, 1'b1} << hgt[N]);
        hgt[N]   = hgt[N] + 1;
        col[W-1] = col[W-1] | ({{(MAXH-1){1'b0}}, 1'b1} << hgt[W-1]);
        hgt[W-1] = hgt[W-1] + 1;
`endif

        for (int k = NDS - 1; k >= 0; k--) begin
            d = dseq(k);
            for (int c = 0; c < W; c++) begin
                ncol[c] = '0;
                nh[c]   = 0;
            end
            for (int c = 0; c < W; c++) begin
                idx = 0;
                for (int t = 0; t < MAXH; t++) begin
                    if (hgt[c] - idx + nh[c] > d) begin
                        sh = col[c] >> idx;
                        x  = sh[0];
                        y  = sh[1];
                        z  = sh[2];
                        if (hgt[c] - idx + nh[c] == d + 1) begin
                            ncol[c] = ncol[c] | ({{(MAXH-1){1'b0}}, x ^ y} << nh[c]);
                            nh[c]   = nh[c] + 1;
                            if (c < W - 1) begin
                                ncol[c+1] = ncol[c+1] | ({{(MAXH-1){1'b0}}, x & y} << nh[c+1]);
                                nh[c+1]   = nh[c+1] + 1;
                            end
                            idx = idx + 2;
                        end else begin
                            ncol[c] = ncol[c] | ({{(MAXH-1){1'b0}}, x ^ y ^ z} << nh[c]);
                            nh[c]   = nh[c] + 1;
                            if (c < W - 1) begin
                                ncol[c+1] = ncol[c+1] |
                                    ({{(MAXH-1){1'b0}}, (x & y) | (x & z) | (y & z)} << nh[c+1]);
                                nh[c+1]   = nh[c+1] + 1;
                            end
                            idx = idx + 3;
                        end
                    end
                end
                // untouched bits pass straight through to the next level
                sh = col[c] >> idx;
                for (int t = 0; t < MAXH; t++) begin
                    if (t < hgt[c] - idx) begin
                        ncol[c] = ncol[c] | ((sh & {{(MAXH-1){1'b0}}, 1'b1}) << nh[c]);
                        nh[c]   = nh[c] + 1;
                        sh      = sh >> 1;
                    end
                end
            end
            for (int c = 0; c < W; c++) begin
                col[c] = ncol[c];
                hgt[c] = nh[c];
            end
        end

        for (int c = 0; c < W; c++) begin
            row0_d[c] = col[c][0];
            row1_d[c] = col[c][1];
        end
    end

    // S3: carry out of bit W-1 cannot be part of an in-range product
    assign mul_d = row0_q + row1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            inflight_q <= '0;
            mul_q      <= '0;
        end else if (en) begin
            vld_pipe_q <= vld_pipe_d;
            inflight_q <= inflight_d;
            if (vld_pipe_q[2]) mul_q <= mul_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            pp_q   <= pp_d;
            row0_q <= row0_d;
            row1_q <= row1_d;
        end
    end
endmodule

// File: tb/tb_dadda_mul_pipe.sv
// Scoreboarded bench for dadda_mul_pipe (N=8 main instance, N=4 corner instance).
// Build with DADDA_SIGNED_EN defined to check the two's-complement configuration.
module tb_dadda_mul_pipe;
    localparam int N = 8;
    localparam int W = 2 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Mul;
    logic [1:0]   in_flight;

    logic         iv4 = 1'b0;
    logic         ir4;
    logic [3:0]   a4 = '0;
    logic [3:0]   b4 = '0;
    logic         ov4;
    logic         ordy4 = 1'b1;
    logic [7:0]   m4;
    logic [1:0]   fl4;

    int npass = 0;
    int ntot  = 0;
    logic [W-1:0] sbq [$];

    dadda_mul_pipe #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Mul(Mul), .in_flight(in_flight)
    );

    dadda_mul_pipe #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .A(a4), .B(b4), .out_valid(ov4), .out_ready(ordy4),
        .Mul(m4), .in_flight(fl4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef DADDA_SIGNED_EN
        logic signed [W-1:0] sa, sb;
        sa = $signed({{N{a[N-1]}}, a});
        sb = $signed({{N{b[N-1]}}, b});
        return W'(sa * sb);
`else
        return {{N{1'b0}}, a} * {{N{1'b0}}, b};
`endif
    endfunction

    // One clock: drive at negedge, sample handshake just after, then take the edge.
    task automatic step(input logic iv, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [W-1:0] e, input logic ordy,
                        output logic ti, output logic to, output logic [W-1:0] ms,
                        output logic ir, output logic [1:0] fl);
        @(negedge clk);
        in_valid  = iv;
        A         = a;
        B         = b;
        out_ready = ordy;
        #1;
        ir = in_ready;
        fl = in_flight;
        ti = in_valid && in_ready;
        to = out_valid && out_ready;
        ms = Mul;
        if (ti) sbq.push_back(e);
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        ntot++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else npass++;
        ntot++; if (Mul !== '0) $display("FAIL reset_mul got %h want 0", Mul); else npass++;
        ntot++; if (in_flight !== 2'd0) $display("FAIL reset_in_flight got %0d want 0", in_flight); else npass++;
        ntot++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else npass++;
    endtask

    task automatic test_basic();
        logic ti, to, ir;
        logic [W-1:0] ms, e, want;
        logic [1:0] fl;
        int lat;
`ifdef DADDA_SIGNED_EN
        want = 16'h0001;
`else
        want = 16'hFE01;
`endif
        step(1'b1, 8'd255, 8'd255, want, 1'b1, ti, to, ms, ir, fl);
        ntot++; if (ti !== 1'b1) $display("FAIL basic_accept got %b want 1", ti); else npass++;
        lat = 0;
        to = 1'b0;
        while (!to && lat < 8) begin
            step(1'b0, '0, '0, '0, 1'b1, ti, to, ms, ir, fl);
            lat++;
        end
        ntot++; if (lat != 3) $display("FAIL basic_latency got %0d want 3", lat); else npass++;
        ntot++;
        if (!to || sbq.size() == 0) $display("FAIL basic_mul got no output want %h", want);
        else begin
            e = sbq.pop_front();
            if (ms !== e) $display("FAIL basic_mul got %h want %h", ms, e); else npass++;
        end
        step(1'b0, '0, '0, '0, 1'b1, ti, to, ms, ir, fl);
        ntot++; if (to !== 1'b0) $display("FAIL basic_valid_drop got %b want 0", to); else npass++;
        ntot++; if (ms !== want) $display("FAIL basic_mul_hold got %h want %h", ms, want); else npass++;
    endtask

    task automatic test_corners();
        logic [N-1:0] ta [4];
        logic [N-1:0] tb [4];
        logic [W-1:0] te [4];
        logic ti, to, ir;
        logic [W-1:0] ms, e;
        logic [1:0] fl;
        int nout, cyc;
`ifdef DADDA_SIGNED_EN
        ta = '{8'h80, 8'hFF, 8'h80, 8'h00};
        tb = '{8'h80, 8'h7F, 8'h7F, 8'hFB};
        te = '{16'h4000, 16'hFF81, 16'hC080, 16'h0000};
`else
        ta = '{8'd0, 8'd1, 8'd128, 8'd255};
        tb = '{8'd200, 8'd173, 8'd2, 8'd1};
        te = '{16'd0, 16'd173, 16'd256, 16'd255};
`endif
        nout = 0;
        cyc = 0;
        while ((cyc < 4 || sbq.size() != 0) && cyc < 24) begin
            if (cyc < 4) step(1'b1, ta[cyc], tb[cyc], te[cyc], 1'b1, ti, to, ms, ir, fl);
            else         step(1'b0, '0, '0, '0, 1'b1, ti, to, ms, ir, fl);
            if (to) begin
                ntot++;
                if (sbq.size() == 0) $display("FAIL corner_extra got %h want none", ms);
                else begin
                    e = sbq.pop_front();
                    if (ms !== e) $display("FAIL corner_%0d got %h want %h", nout, ms, e); else npass++;
                end
                nout++;
            end
            cyc++;
        end
        ntot++; if (nout != 4) $display("FAIL corner_count got %0d want 4", nout); else npass++;
    endtask

    task automatic test_n4();
        logic [7:0] want;
        int cyc;
`ifdef DADDA_SIGNED_EN
        want = 8'h01;
`else
        want = 8'd225;
`endif
        @(negedge clk);
        iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
        #1;
        ntot++; if (ir4 !== 1'b1) $display("FAIL n4_ready got %b want 1", ir4); else npass++;
        @(negedge clk);
        iv4 = 1'b0;
        cyc = 0;
        while (ov4 !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        ntot++;
        if (ov4 !== 1'b1) $display("FAIL n4_timeout got no output want %0d", want);
        else if (m4 !== want) $display("FAIL n4_mul got %0d want %0d", m4, want);
        else npass++;
    endtask

    task automatic test_back_to_back();
        logic ti, to, ir;
        logic [W-1:0] ms, e;
        logic [1:0] fl;
        logic [N-1:0] a, b;
        logic iv;
        int nout, nstall, first, last;
        nout = 0; nstall = 0; first = -1; last = -1;
        for (int i = 0; i < 264; i++) begin
            iv = (i < 256);
            a  = N'($urandom);
            b  = N'($urandom);
            step(iv, a, b, model(a, b), 1'b1, ti, to, ms, ir, fl);
            if (iv && !ir) nstall++;
            if (to) begin
                ntot++;
                if (sbq.size() == 0) $display("FAIL stream_extra got %h want none", ms);
                else begin
                    e = sbq.pop_front();
                    if (ms !== e) $display("FAIL stream_mul got %h want %h", ms, e); else npass++;
                end
                if (first < 0) first = i;
                last = i;
                nout++;
            end
        end
        ntot++; if (nstall != 0) $display("FAIL stream_in_ready got %0d stalls want 0", nstall); else npass++;
        ntot++; if (nout != 256) $display("FAIL stream_count got %0d want 256", nout); else npass++;
        ntot++; if (last - first != 255) $display("FAIL stream_rate got span %0d want 255", last - first); else npass++;
    endtask

    task automatic test_stall();
        logic ti, to, ir;
        logic [W-1:0] ms, e;
        logic [1:0] fl;
        logic [N-1:0] a, b;
        int nin, nout, cyc;
        nin = 0;
        for (int i = 0; i < 3; i++) begin
            a = N'($urandom); b = N'($urandom);
            step(1'b1, a, b, model(a, b), 1'b0, ti, to, ms, ir, fl);
            if (ti) nin++;
        end
        ntot++; if (nin != 3) $display("FAIL stall_accept got %0d want 3", nin); else npass++;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h5A, 8'hA5, model(8'h5A, 8'hA5), 1'b0, ti, to, ms, ir, fl);
            ntot++; if (ir !== 1'b0) $display("FAIL stall_in_ready got %b want 0", ir); else npass++;
            ntot++; if (fl !== 2'd3) $display("FAIL stall_in_flight got %0d want 3", fl); else npass++;
            ntot++;
            if (sbq.size() == 0) $display("FAIL stall_mul got %h want queued product", ms);
            else if (ms !== sbq[0]) $display("FAIL stall_mul got %h want %h", ms, sbq[0]);
            else npass++;
        end
        nout = 0; cyc = 0;
        while (sbq.size() != 0 && cyc < 12) begin
            step(1'b0, '0, '0, '0, 1'b1, ti, to, ms, ir, fl);
            if (to) begin
                ntot++;
                e = sbq.pop_front();
                if (ms !== e) $display("FAIL stall_drain got %h want %h", ms, e); else npass++;
                nout++;
            end
            cyc++;
        end
        ntot++; if (nout != 3) $display("FAIL stall_drain_count got %0d want 3", nout); else npass++;
        step(1'b0, '0, '0, '0, 1'b1, ti, to, ms, ir, fl);
        ntot++; if (to !== 1'b0) $display("FAIL stall_dup got %b want 0", to); else npass++;
        ntot++; if (fl !== 2'd0) $display("FAIL stall_empty got %0d want 0", fl); else npass++;
    endtask

    task automatic test_random_bp();
        logic ti, to, ir;
        logic [W-1:0] ms, e;
        logic [1:0] fl;
        logic [N-1:0] a, b;
        int nin, nout, cyc;
        nin = 0; nout = 0;
        for (int i = 0; i < 200; i++) begin
            a = N'($urandom); b = N'($urandom);
            step(1'($urandom_range(0, 1)), a, b, model(a, b), 1'($urandom_range(0, 1)), ti, to, ms, ir, fl);
            if (ti) nin++;
            if (to) begin
                ntot++;
                if (sbq.size() == 0) $display("FAIL bp_extra got %h want none", ms);
                else begin
                    e = sbq.pop_front();
                    if (ms !== e) $display("FAIL bp_mul got %h want %h", ms, e); else npass++;
                end
                nout++;
            end
        end
        cyc = 0;
        while (sbq.size() != 0 && cyc < 12) begin
            step(1'b0, '0, '0, '0, 1'b1, ti, to, ms, ir, fl);
            if (to) begin
                ntot++;
                e = sbq.pop_front();
                if (ms !== e) $display("FAIL bp_drain got %h want %h", ms, e); else npass++;
                nout++;
            end
            cyc++;
        end
        ntot++; if (nout != nin) $display("FAIL bp_count got %0d want %0d", nout, nin); else npass++;
    endtask

    task automatic test_reset_midstream();
        logic ti, to, ir;
        logic [W-1:0] ms;
        logic [1:0] fl;
        int nout;
        step(1'b1, 8'd77, 8'd91, model(8'd77, 8'd91), 1'b1, ti, to, ms, ir, fl);
        step(1'b1, 8'd13, 8'd250, model(8'd13, 8'd250), 1'b1, ti, to, ms, ir, fl);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        ntot++; if (in_flight !== 2'd2) $display("FAIL mid_in_flight got %0d want 2", in_flight); else npass++;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        ntot++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", out_valid); else npass++;
        ntot++; if (Mul !== '0) $display("FAIL mid_mul got %h want 0", Mul); else npass++;
        ntot++; if (in_flight !== 2'd0) $display("FAIL mid_in_flight_rst got %0d want 0", in_flight); else npass++;
        ntot++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got %b want 1", in_ready); else npass++;
        rst_n = 1'b1;
        sbq.delete();
        nout = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, ti, to, ms, ir, fl);
            if (to) nout++;
        end
        ntot++; if (nout != 0) $display("FAIL mid_stale got %0d outputs want 0", nout); else npass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_n4();
        test_back_to_back();
        test_stall();
        test_random_bp();
        test_reset_midstream();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
